// File: rtl/button_debounce_pkg.sv
// Shared types, defaults and helpers for the pushbutton debouncer and its synchroniser.
// The simulation defaults keep debounce and long-press windows short enough to step through.
`timescale 1ns/1ps
package button_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } btn_state_e;

`ifdef SIMULATION
   localparam int DEF_DEBOUNCE_CYCLES   = 4;
   localparam int DEF_LONG_PRESS_CYCLES = 32;
`else
   localparam int DEF_DEBOUNCE_CYCLES   = 1 << 17;
   localparam int DEF_LONG_PRESS_CYCLES = 1 << 24;
`endif

   localparam int SYNC_STAGES = 2;

   // Registered output bundle; every field is driven straight from a flop.
   typedef struct packed {
      logic pressed;
      logic press_pulse;
      logic release_pulse;
      logic long_pulse;
   } btn_out_t;

   // Width that holds the larger of the two cycle counts, including the saturation value.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button pin and conditioned event signals between the board logic and the debouncer.
`timescale 1ns/1ps
interface button_debounce_if;
   logic BTN_RAW;
   logic PRESSED;
   logic PRESS_PULSE;
   logic RELEASE_PULSE;
   logic LONG_PULSE;

   modport master (
      output BTN_RAW,
      input  PRESSED,
      input  PRESS_PULSE,
      input  RELEASE_PULSE,
      input  LONG_PULSE
   );

   modport slave (
      input  BTN_RAW,
      output PRESSED,
      output PRESS_PULSE,
      output RELEASE_PULSE,
      output LONG_PULSE
   );
endinterface

// File: rtl/button_debounce_sync.sv
// Two-flop synchroniser for a single asynchronous board pin; clears to 0 on reset.
`timescale 1ns/1ps
module sync_2ff
   import button_debounce_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stage_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stage_reg <= '0;
      end else begin
         stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Pushbutton conditioner: synchronise, debounce, and emit single-cycle press, release and
// long-press pulses alongside a clean held level.
`timescale 1ns/1ps
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter bit ACTIVE_LOW        = 1'b1,
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
)(
   input  logic              CLK,
   input  logic              RST,
   button_debounce_if.slave  btn
);

   localparam int               CNT_W     = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit               LONG_EN   = (LONG_PRESS_CYCLES > 0);
   localparam logic [CNT_W-1:0] LONG_LAST = LONG_EN ? CNT_W'(LONG_PRESS_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_PRESS_CYCLES);

   logic btn_level;
   logic s;

   btn_state_e       state_reg, state_next;
   logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
   logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic             long_fired_reg, long_fired_next;
   btn_out_t         out_reg, out_next;

   // Normalise polarity so 1 always means "pressed" from here on.
   assign btn_level = btn.BTN_RAW ^ ACTIVE_LOW;

   sync_2ff u_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (btn_level),
      .q   (s)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg      <= IDLE;
         db_cnt_reg     <= '0;
         hold_cnt_reg   <= '0;
         long_fired_reg <= 1'b0;
         out_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         db_cnt_reg     <= db_cnt_next;
         hold_cnt_reg   <= hold_cnt_next;
         long_fired_reg <= long_fired_next;
         out_reg        <= out_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      db_cnt_next     = '0;
      hold_cnt_next   = hold_cnt_reg;
      long_fired_next = long_fired_reg;
      out_next        = '0;
      out_next.pressed = out_reg.pressed;

      // Hold timing runs for as long as the debounced level says pressed, so a
      // rejected release bounce neither restarts it nor re-arms the long pulse.
      if (LONG_EN && out_reg.pressed) begin
         if (hold_cnt_reg != LONG_SAT) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
         end
         if (hold_cnt_reg == LONG_LAST && !long_fired_reg) begin
            out_next.long_pulse = 1'b1;
            long_fired_next     = 1'b1;
         end
      end

      case (state_reg)
         IDLE: begin
            if (s) begin
               state_next = DB_PRESS;
            end
         end
         DB_PRESS: begin
            if (!s) begin
               state_next = IDLE;
            end else if (db_cnt_reg == DB_LAST) begin
               state_next           = HELD;
               out_next.press_pulse = 1'b1;
               out_next.pressed     = 1'b1;
               hold_cnt_next        = '0;
               long_fired_next      = 1'b0;
            end else begin
               db_cnt_next = db_cnt_reg + 1'b1;
            end
         end
         HELD: begin
            if (!s) begin
               state_next = DB_RELEASE;
            end
         end
         DB_RELEASE: begin
            if (s) begin
               state_next = HELD;
            end else if (db_cnt_reg == DB_LAST) begin
               // An accepted release outranks a long pulse due on the same edge.
               state_next             = IDLE;
               out_next.release_pulse = 1'b1;
               out_next.pressed       = 1'b0;
               out_next.long_pulse    = 1'b0;
            end else begin
               db_cnt_next = db_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next      = IDLE;
            hold_cnt_next   = '0;
            long_fired_next = 1'b0;
            out_next        = '0;
         end
      endcase
   end

   assign btn.PRESSED       = out_reg.pressed;
   assign btn.PRESS_PULSE   = out_reg.press_pulse;
   assign btn.RELEASE_PULSE = out_reg.release_pulse;
   assign btn.LONG_PULSE    = out_reg.long_pulse;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: two instances (long press enabled / disabled) share one pin stimulus;
// expected pulses are queued with their due cycle and matched as the outputs appear.
`timescale 1ns/1ps
module tb_button_debounce;

   localparam int DB = 4;
   localparam int LP = 32;
   localparam int NV = 10;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   button_debounce_if bus_a ();
   button_debounce_if bus_b ();

   button_debounce #(.ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)) dut_a (
      .CLK (CLK),
      .RST (RST),
      .btn (bus_a)
   );

   button_debounce #(.ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(0)) dut_b (
      .CLK (CLK),
      .RST (RST),
      .btn (bus_b)
   );

   typedef struct {
      int dut;
      int cyc;
      int kind;   // 0 press, 1 release, 2 long
   } ev_t;

   typedef struct {
      int len;       // cycles the pin is held pressed
      int glitch;    // hold cycle with a one-cycle release bounce, 0 = none
      bit exp_press;
      bit exp_long;  // only for the instance with long press enabled
   } vec_t;

   ev_t   sbq[$];
   vec_t  vecs[NV];
   int    cyc = 0;
   logic  rst_q = 1'b1;
   bit    mon_en = 1'b0;
   int    n_checks = 0;
   int    n_errors = 0;
   logic [2:0] mon_pl [2];
   logic       mon_pr [2];
   logic       prev_pr [2];
   string      kname [3];

   assign mon_pl[0] = {bus_a.LONG_PULSE, bus_a.RELEASE_PULSE, bus_a.PRESS_PULSE};
   assign mon_pl[1] = {bus_b.LONG_PULSE, bus_b.RELEASE_PULSE, bus_b.PRESS_PULSE};
   assign mon_pr[0] = bus_a.PRESSED;
   assign mon_pr[1] = bus_b.PRESSED;

   always @(posedge CLK) begin
      cyc   <= cyc + 1;
      rst_q <= RST;
   end

   function automatic int find_ev(input int d, input int c, input int k);
      foreach (sbq[i]) begin
         if (sbq[i].dut == d && sbq[i].cyc == c && sbq[i].kind == k) return i;
      end
      return -1;
   endfunction

   // Scoreboard monitor: every observed pulse must match a queued expectation exactly.
   always @(negedge CLK) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ($countones(mon_pl[d]) > 1) begin
               n_errors++;
               $display("FAIL one_pulse dut%0d cyc %0d: pulses=%b, required at most one high", d, cyc, mon_pl[d]);
            end
            if (!rst_q) begin
               n_checks++;
               if (mon_pr[d] != prev_pr[d] && mon_pl[d][1:0] == 2'b00) begin
                  n_errors++;
                  $display("FAIL pressed_edge dut%0d cyc %0d: PRESSED %b->%b without press/release pulse", d, cyc, prev_pr[d], mon_pr[d]);
               end
            end
            for (int k = 0; k < 3; k++) begin
               if (mon_pl[d][k]) begin
                  int idx;
                  n_checks++;
                  idx = find_ev(d, cyc, k);
                  if (idx < 0) begin
                     n_errors++;
                     $display("FAIL %s_pulse dut%0d cyc %0d: got 1, required 0 (unexpected)", kname[k], d, cyc);
                  end else begin
                     sbq.delete(idx);
                  end
               end
            end
            prev_pr[d] <= mon_pr[d];
         end
         for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc < cyc) begin
               n_checks++;
               n_errors++;
               $display("FAIL %s_pulse dut%0d cyc %0d: got 0, required 1 (missed)", kname[sbq[i].kind], sbq[i].dut, sbq[i].cyc);
               sbq.delete(i);
            end
         end
      end
   end

   task automatic push(input int d, input int c, input int k);
      ev_t e;
      e.dut  = d;
      e.cyc  = c;
      e.kind = k;
      sbq.push_back(e);
   endtask

   task automatic push_both(input int c, input int k);
      push(0, c, k);
      if (k != 2) push(1, c, k);
   endtask

   task automatic check_bit(input string nm, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc %0d: got %b, required %b", nm, cyc, got, exp);
      end
   endtask

   task automatic drive(input logic raw);
      bus_a.BTN_RAW = raw;
      bus_b.BTN_RAW = raw;
   endtask

   task automatic check_pressed(input string nm, input logic exp);
      check_bit({nm, "_a"}, bus_a.PRESSED, exp);
      check_bit({nm, "_b"}, bus_b.PRESSED, exp);
   endtask

   task automatic check_all_zero(input string nm);
      check_bit({nm, "_pressed_a"}, bus_a.PRESSED, 1'b0);
      check_bit({nm, "_press_a"},   bus_a.PRESS_PULSE, 1'b0);
      check_bit({nm, "_release_a"}, bus_a.RELEASE_PULSE, 1'b0);
      check_bit({nm, "_long_a"},    bus_a.LONG_PULSE, 1'b0);
      check_bit({nm, "_pressed_b"}, bus_b.PRESSED, 1'b0);
      check_bit({nm, "_press_b"},   bus_b.PRESS_PULSE, 1'b0);
      check_bit({nm, "_release_b"}, bus_b.RELEASE_PULSE, 1'b0);
      check_bit({nm, "_long_b"},    bus_b.LONG_PULSE, 1'b0);
   endtask

   initial begin
      int c0;
      int r;
      int c1;

      kname[0] = "press";
      kname[1] = "release";
      kname[2] = "long";
      prev_pr[0] = 1'b0;
      prev_pr[1] = 1'b0;

      // len, glitch, exp_press, exp_long
      vecs[0] = '{20,  0, 1'b1, 1'b0};   // clean press
      vecs[1] = '{4,   0, 1'b0, 1'b0};   // one cycle too short to be accepted
      vecs[2] = '{5,   0, 1'b1, 1'b0};   // shortest accepted press
      vecs[3] = '{40,  0, 1'b1, 1'b1};   // long press
      vecs[4] = '{40, 30, 1'b1, 1'b1};   // release bounce mid-hold
      vecs[5] = '{40, 35, 1'b1, 1'b1};   // long pulse due while in release debounce
      vecs[6] = '{31,  0, 1'b1, 1'b0};   // release one edge before long
      vecs[7] = '{32,  0, 1'b1, 1'b0};   // release on the long edge: release wins
      vecs[8] = '{33,  0, 1'b1, 1'b1};   // long one edge before release
      vecs[9] = '{100, 0, 1'b1, 1'b1};   // very long hold

      drive(1'b1);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      check_all_zero("reset");
      RST = 1'b0;
      mon_en = 1'b1;
      repeat (5) @(negedge CLK);

      // Edge driven at cycle c0 is first sampled at edge c0+1; pulses appear 2+DB edges later.
      for (int v = 0; v < NV; v++) begin
         c0 = cyc;
         if (vecs[v].exp_press) push_both(c0 + 3 + DB, 0);
         if (vecs[v].exp_long)  push(0, c0 + 3 + DB + LP, 2);
         if (vecs[v].exp_press) push_both(c0 + vecs[v].len + 3 + DB, 1);
         for (int i = 0; i < vecs[v].len + 15; i++) begin
            if (i < vecs[v].len && !(vecs[v].glitch != 0 && i == vecs[v].glitch)) drive(1'b0);
            else drive(1'b1);
            if (i == 8) check_pressed($sformatf("vec%0d_held", v), vecs[v].exp_press);
            @(negedge CLK);
         end
         check_pressed($sformatf("vec%0d_after", v), 1'b0);
         $display("vector %0d: len=%0d glitch=%0d press=%0d long=%0d", v, vecs[v].len, vecs[v].glitch, vecs[v].exp_press, vecs[v].exp_long);
      end

      // Pin toggling every 2 cycles never stays stable long enough.
      for (int i = 0; i < 27; i++) begin
         if (i < 12 && ((i / 2) % 2 == 0)) drive(1'b0);
         else drive(1'b1);
         if (i % 4 == 3) check_pressed("bounce", 1'b0);
         @(negedge CLK);
      end
      $display("bounce sequence done at cyc %0d", cyc);

      // Reset while held: fresh press after reset, no release for the interrupted press.
      c0 = cyc;
      push_both(c0 + 3 + DB, 0);
      drive(1'b0);
      repeat (12) @(negedge CLK);
      check_pressed("pre_reset", 1'b1);
      r = cyc;
      RST = 1'b1;
      @(negedge CLK);
      check_all_zero("mid_reset");
      RST = 1'b0;
      push_both(r + 4 + DB, 0);
      repeat (13) @(negedge CLK);
      check_pressed("post_reset_held", 1'b1);
      c1 = cyc;
      push_both(c1 + 3 + DB, 1);
      drive(1'b1);
      repeat (15) @(negedge CLK);
      check_pressed("post_reset_released", 1'b0);
      $display("reset-while-held sequence done at cyc %0d", cyc);

      repeat (5) @(negedge CLK);
      n_checks++;
      if (sbq.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_empty: %0d expected pulses outstanding, required 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
